// File: rtl/uart_pkg.sv
// Shared types and widths for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic {IDLE, SEND} arb_state_t;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned BURST_CNT_W = 8;
  localparam int unsigned IDLE_CNT_W  = 16;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request strictly above `last`, wrapping around.
module uart_rr_pick #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     pick,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;

  // The upper copy of the doubled vector supplies the wrap-around candidates.
  always_comb begin
    dbl = {req, req};
    for (int unsigned i = 0; i < 2*N; i++) begin
      masked[i] = dbl[i] && (i > 32'(last));
    end
    any = |req;
    idx = '0;
    for (int unsigned i = 2*N; i > 0; i--) begin
      if (masked[i-1]) begin
        idx = IDX_W'((i - 1) % N);
      end
    end
    pick      = '0;
    pick[idx] = any;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular sharing of one UART transmit shift register
// between NUM_REQ byte-stream requesters.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned IDLE_TIMEOUT = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      abort
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [BURST_CNT_W-1:0] BURST_LIM = BURST_CNT_W'(MAX_BURST - 1);
  localparam logic [IDLE_CNT_W-1:0]  IDLE_LIM  = IDLE_CNT_W'(IDLE_TIMEOUT - 1);

  arb_state_t             state, state_nxt;
  logic [NUM_REQ-1:0]     grant_nxt;
  logic [IDX_W-1:0]       gidx, gidx_nxt;
  logic [IDX_W-1:0]       last_grant, last_grant_nxt;
  logic [BURST_CNT_W-1:0] burst_cnt, burst_nxt;
  logic [IDLE_CNT_W-1:0]  idle_cnt, idle_nxt;
  logic                   timeout_rel;

  logic [NUM_REQ-1:0]     pick_onehot;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;

  uart_rr_pick #(.N(NUM_REQ)) u_pick (
    .req  (req_valid),
    .last (last_grant),
    .pick (pick_onehot),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      gidx       <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      burst_cnt  <= '0;
      idle_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      gidx       <= gidx_nxt;
      last_grant <= last_grant_nxt;
      burst_cnt  <= burst_nxt;
      idle_cnt   <= idle_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    gidx_nxt       = gidx;
    last_grant_nxt = last_grant;
    burst_nxt      = burst_cnt;
    idle_nxt       = idle_cnt;
    timeout_rel    = 1'b0;
    req_ready      = '0;
    tx_valid       = 1'b0;
    tx_data        = '0;
    busy           = 1'b0;

    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = SEND;
          grant_nxt = pick_onehot;
          gidx_nxt  = pick_idx;
          burst_nxt = '0;
          idle_nxt  = '0;
        end
      end
      SEND: begin
        busy            = 1'b1;
        tx_valid        = req_valid[gidx];
        tx_data         = req_data[BYTE_W*int'(gidx) +: BYTE_W];
        req_ready[gidx] = tx_ready;
        if (req_valid[gidx] && tx_ready) begin
          burst_nxt = burst_cnt + BURST_CNT_W'(1);
          idle_nxt  = '0;
          if (req_last[gidx] || burst_cnt == BURST_LIM) begin
            state_nxt      = IDLE;
            grant_nxt      = '0;
            last_grant_nxt = gidx;
          end
        end else if (!req_valid[gidx]) begin
          // A stalled shift register (valid high, tx_ready low) never ages the grant.
          if (idle_cnt == IDLE_LIM) begin
            timeout_rel    = 1'b1;
            state_nxt      = IDLE;
            grant_nxt      = '0;
            last_grant_nxt = gidx;
          end else begin
            idle_nxt = idle_cnt + IDLE_CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign abort = timeout_rel && !rst;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit shift register between NUM_REQ byte-stream requesters, using round-robin arbitration at packet granularity.
- Grant is held until the requester's last byte, the MAX_BURST byte limit, or an idle timeout, whichever comes first.
- Sits between the requester blocks (CPU mailbox, debug dump, status reporter) and the shift register's load interface (tx_ready = shift-register-empty).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 16, maximum bytes per grant before forced release (1..255).
- IDLE_TIMEOUT, 1000, cycles a granted requester may leave req_valid low mid-packet before release (1..65535).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  NUM_REQ*8  byte of requester i at bits [8i+7:8i].
- req_last  input  NUM_REQ  byte is the final byte of the packet.
- req_ready  output  NUM_REQ  byte accepted this cycle.
- tx_data  output  8  byte to the shift register.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  shift register empty, can load.
- grant  output  NUM_REQ  one-hot current owner; all zero when idle.
- busy  output  1  high in SEND.
- abort  output  1  one-cycle pulse when a grant is released by timeout.

Behaviour:
- Reset (synchronous, rst high at clk edge):
  - State = IDLE, grant = 0, busy = 0, abort = 0.
  - req_ready = 0, tx_valid = 0, tx_data = 0.
  - last_grant pointer = NUM_REQ-1, so requester 0 has first priority.
  - burst_cnt and idle_cnt = 0.
- Reset mid-packet: the byte in flight is dropped with no handshake, and no abort pulse is generated.
- FSM states: IDLE, SEND.
- IDLE:
  - If any req_valid is high, pick the first set bit searching upward from last_grant+1, with wrap-around.
  - Register grant, clear burst_cnt and idle_cnt, and enter SEND the next cycle.
  - Arbitration latency is exactly 1 cycle from the request being seen in IDLE to grant being visible.
- SEND, with g = granted index:
  - tx_valid = req_valid[g] and tx_data = req_data[g] (combinational pass-through).
  - req_ready[g] = tx_ready; all other req_ready = 0.
  - Transfer occurs when req_valid[g] && tx_ready.
- On a transfer:
  - burst_cnt increments and idle_cnt clears.
  - If req_last[g] is high, or burst_cnt == MAX_BURST-1: next state IDLE, last_grant <= g, grant <= 0.
- No transfer while req_valid[g] = 0:
  - idle_cnt increments.
  - When idle_cnt == IDLE_TIMEOUT-1: next state IDLE, last_grant <= g, grant <= 0, abort pulses for 1 cycle.
- No transfer because tx_ready = 0 with req_valid[g] = 1: idle_cnt does not increment, so a slow baud never causes a timeout.
- After any release there is always one IDLE cycle before the next grant, even if requests are pending.
- Non-granted requesters' valid and data are ignored. Their req_valid may drop before being granted without penalty.
- A single requester may be re-granted immediately after its own release if no other requester is valid.
- Width rules:
  - burst_cnt is 8 bits and idle_cnt is 16 bits.
  - Comparisons use the parameter minus 1.
  - MAX_BURST = 1 releases after every byte.
- tx_valid never asserts outside SEND. grant is one-hot or zero at all times.

Decomposition:
- Package uart_pkg:
  - arb_state_t enum {IDLE, SEND}.
  - Constants BYTE_W = 8, BURST_CNT_W = 8, IDLE_CNT_W = 16.
- Sub-module uart_rr_pick: combinational round-robin picker.
  - Inputs: request vector, last_grant index.
  - Outputs: one-hot pick, index, any.
  - Implemented via a double-width request vector and masking.

Test Plan:
- Req0 sends a 3-byte packet 0x41,0x42,0x43 (last on 0x43), tx_ready always 1 -> grant = 0001 one cycle after the first req_valid; tx_data 41,42,43 on consecutive cycles; grant = 0 the cycle after 0x43.
- Req1 and req3 both valid in IDLE with last_grant = 1, each sending 1-byte packets -> req3 is granted first, then req1 after one IDLE bubble.
- MAX_BURST = 4, req2 streams 10 bytes with no last -> releases after byte 4 and byte 8; with req0 also pending, req0 is served between req2's bursts.
- Req0 granted, sends 1 byte, then drops valid, IDLE_TIMEOUT = 20 -> abort pulses exactly 20 cycles after the last transfer, grant = 0, and other requesters are arbitrated next.
- tx_ready held low 5000 cycles while req1 is valid -> no abort, no byte lost; the byte transfers on the first cycle tx_ready = 1.
- rst asserted in SEND mid-packet -> next cycle grant = 0, tx_valid = 0, busy = 0, no abort pulse; after rst deasserts, requester 0 has first priority.
